// File: rtl/barrel_pipe.sv
// Pipelined barrel shifter/rotator: log2(WIDTH) levels split over STAGES register stages; latency STAGES cycles.
// A stalled output freezes the whole pipe and drops o_ready. Sign-fill SRA only with BARREL_SRA_EN.
module barrel_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_amt,
    input  logic [2:0]               i_op,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_zero
);
    localparam int L = $clog2(WIDTH);
    localparam int G = (L + STAGES - 1) / STAGES;

    logic [WIDTH-1:0] data_q [STAGES];
    logic [WIDTH-1:0] data_d [STAGES];
    logic [2:0]       op_q   [STAGES];
    logic [2:0]       op_d   [STAGES];
    logic [L-1:0]     amt_q  [STAGES];
    logic [L-1:0]     amt_d  [STAGES];
    logic             vld_q  [STAGES];
    logic             vld_d  [STAGES];

    logic [WIDTH-1:0] stg_dat [STAGES];
    logic [2:0]       stg_op  [STAGES];
    logic [L-1:0]     stg_amt [STAGES];
    logic             stg_vld [STAGES];
    logic             en;

    // One shift level by a fixed power-of-two distance.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                     input logic [2:0] op,
                                                     input int sh);
        logic [WIDTH-1:0] r;
        r = x;
        case (op)
            3'b001: r = x << sh;
            3'b010: r = x >> sh;
`ifdef BARREL_SRA_EN
            3'b011: r = $signed(x) >>> sh;
`else
            3'b011: r = x >> sh;
`endif
            3'b100: r = (x << sh) | (x >> (WIDTH - sh));
            3'b101: r = (x >> sh) | (x << (WIDTH - sh));
            default: r = x;
        endcase
        return r;
    endfunction

    always_comb begin
        logic [WIDTH-1:0] cur;
        cur = '0;
        en  = !vld_q[STAGES-1] || i_ready;

        stg_dat[0] = i_data;
        stg_op[0]  = i_op;
        stg_amt[0] = i_amt;
        stg_vld[0] = i_valid;
        for (int k = 1; k < STAGES; k++) begin
            stg_dat[k] = data_q[k-1];
            stg_op[k]  = op_q[k-1];
            stg_amt[k] = amt_q[k-1];
            stg_vld[k] = vld_q[k-1];
        end

        // Stage k owns levels k*G .. (k+1)*G-1; stages past L are plain registers.
        for (int k = 0; k < STAGES; k++) begin
            cur = stg_dat[k];
            for (int j = 0; j < L; j++) begin
                if (j >= k * G && j < (k + 1) * G && stg_amt[k][j]) begin
                    cur = shift_level(cur, stg_op[k], 1 << j);
                end
            end
            data_d[k] = en ? cur        : data_q[k];
            op_d[k]   = en ? stg_op[k]  : op_q[k];
            amt_d[k]  = en ? stg_amt[k] : amt_q[k];
            vld_d[k]  = en ? stg_vld[k] : vld_q[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                op_q[k]   <= '0;
                amt_q[k]  <= '0;
                vld_q[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                op_q[k]   <= op_d[k];
                amt_q[k]  <= amt_d[k];
                vld_q[k]  <= vld_d[k];
            end
        end
    end

    assign o_ready = en;
    assign o_valid = vld_q[STAGES-1];
    assign o_data  = data_q[STAGES-1];
    assign o_zero  = (data_q[STAGES-1] == '0);

endmodule

// File: tb/tb_barrel_pipe.sv
// Bench for barrel_pipe: four instances (STAGES 2,1,3,5) checked against an arithmetic reference model.
module tb_barrel_pipe;
    localparam logic [2:0] OP_PASS = 3'b000, OP_SLL = 3'b001, OP_SRL = 3'b010,
                           OP_SRA = 3'b011, OP_ROL = 3'b100, OP_ROR = 3'b101;

    logic        clk;
    logic        rst;
    logic        in_vld  [4];
    logic        in_rdy  [4];
    logic [31:0] in_dat  [4];
    logic [4:0]  in_amt  [4];
    logic [2:0]  in_op   [4];
    logic        out_vld [4];
    logic        out_rdy [4];
    logic [31:0] out_dat [4];
    logic        zero    [4];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        barrel_pipe #(
            .WIDTH (32),
            .STAGES((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 5)
        ) u_dut (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_valid(in_vld[g]),
            .o_ready(in_rdy[g]),
            .i_data (in_dat[g]),
            .i_amt  (in_amt[g]),
            .i_op   (in_op[g]),
            .o_valid(out_vld[g]),
            .i_ready(out_rdy[g]),
            .o_data (out_dat[g]),
            .o_zero (zero[g])
        );
    end

    function automatic int stg(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 5;
    endfunction

    // Whole-amount arithmetic: shifts on a widened word, rotates on a doubled word.
    function automatic logic [31:0] ref_model(input logic [31:0] d, input int a, input logic [2:0] op);
        logic [63:0] w;
        case (op)
            OP_SLL: return d << a;
            OP_SRL: return d >> a;
            OP_SRA: begin
`ifdef BARREL_SRA_EN
                w = {{32{d[31]}}, d} >> a;
                return w[31:0];
`else
                return d >> a;
`endif
            end
            OP_ROL: begin
                w = {d, d} << a;
                return w[63:32];
            end
            OP_ROR: begin
                w = {d, d} >> a;
                return w[31:0];
            end
            default: return d;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input int g, input logic [31:0] d, input logic [4:0] a,
                           input logic [2:0] op, input logic [31:0] e, input string tag);
        int lat;
        out_rdy[g] = 1'b1;
        in_vld[g]  = 1'b1;
        in_dat[g]  = d;
        in_amt[g]  = a;
        in_op[g]   = op;
        #1;
        chk({tag, "_rdy"}, in_rdy[g], 1);
        step();
        in_vld[g] = 1'b0;
        in_dat[g] = $urandom;
        lat = 1;
        while (out_vld[g] !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, stg(g));
        chk({tag, "_dat"}, out_dat[g], e);
        chk({tag, "_zero"}, zero[g], (e == 32'h0));
        step();
        chk({tag, "_drain"}, out_vld[g], 0);
    endtask

    // Cycle-level stream against a pipe model of STAGES slots that all advance together.
    task automatic stream(input int g, input int n, input int stall_at, input int stall_len,
                          input bit rnd_gap, input bit rnd_rdy, input string tag);
        bit          mv[$];
        logic [31:0] md[$];
        int          s, issued, delivered, inflight, cyc;
        bit          pend, en, ev;
        logic [31:0] pd, ed;
        logic [4:0]  pa;
        logic [2:0]  po;
        s = stg(g);
        issued = 0; delivered = 0; inflight = 0; cyc = 0;
        pend = 1'b0; pd = '0; pa = '0; po = '0;
        for (int i = 0; i < s; i++) begin
            mv.push_back(1'b0);
            md.push_back(32'h0);
        end
        while ((issued < n || inflight > 0) && cyc < n * 8 + 100) begin
            if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) out_rdy[g] = 1'b0;
            else if (rnd_rdy) out_rdy[g] = ($urandom_range(0, 3) != 0);
            else out_rdy[g] = 1'b1;
            if (!pend && issued < n && (!rnd_gap || $urandom_range(0, 4) != 0)) begin
                pend = 1'b1;
                pd   = $urandom;
                pa   = 5'($urandom_range(0, 31));
                po   = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) pd = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            end
            in_vld[g] = pend;
            in_dat[g] = pend ? pd : $urandom;
            in_amt[g] = pend ? pa : 5'($urandom);
            in_op[g]  = pend ? po : 3'($urandom);
            #1;
            ev = mv[s-1];
            ed = md[s-1];
            en = !ev || out_rdy[g];
            chk({tag, "_vld"}, out_vld[g], ev);
            chk({tag, "_rdy"}, in_rdy[g], en);
            if (ev) begin
                chk({tag, "_dat"}, out_dat[g], ed);
                chk({tag, "_zero"}, zero[g], (ed == 32'h0));
                if (out_rdy[g]) begin
                    delivered++;
                    inflight--;
                end
            end
            if (en) begin
                void'(mv.pop_back());
                void'(md.pop_back());
                mv.push_front(pend);
                md.push_front(pend ? ref_model(pd, pa, po) : 32'h0);
                if (pend) begin
                    issued++;
                    inflight++;
                    pend = 1'b0;
                end
            end
            step();
            cyc++;
        end
        chk({tag, "_count"}, delivered, n);
        in_vld[g]  = 1'b0;
        out_rdy[g] = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            in_vld[g]  = 1'b0;
            in_dat[g]  = '0;
            in_amt[g]  = '0;
            in_op[g]   = '0;
            out_rdy[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("reset_vld",  out_vld[g], 0);
            chk("reset_dat",  out_dat[g], 0);
            chk("reset_zero", zero[g], 1);
            chk("reset_rdy",  in_rdy[g], 1);
        end
        rst = 1'b0;
        for (int g = 0; g < 4; g++) out_rdy[g] = 1'b1;
        step();

        run_one(0, 32'h0000_0001, 5'd31, OP_SLL, 32'h8000_0000, "sll31");
        run_one(0, 32'h0000_000F, 5'd4,  OP_ROR, 32'hF000_0000, "ror4");
        run_one(0, 32'h8000_0001, 5'd1,  OP_ROL, 32'h0000_0003, "rol1");
        r = $urandom;
        run_one(0, r,             5'd0,  OP_ROL, r,             "rol0");
`ifdef BARREL_SRA_EN
        run_one(0, 32'h8000_0000, 5'd4,  OP_SRA, 32'hF800_0000, "sra4");
`else
        run_one(0, 32'h8000_0000, 5'd4,  OP_SRA, 32'h0800_0000, "sra4");
`endif
        run_one(0, 32'h8000_0000, 5'd31, OP_SRL, 32'h0000_0001, "srl31");
        run_one(0, 32'hDEAD_BEEF, 5'd7,  3'b110, 32'hDEAD_BEEF, "pass110");
        run_one(0, 32'h0000_00A5, 5'd9,  OP_PASS, 32'h0000_00A5, "pass000");
        run_one(0, 32'hFFFF_0000, 5'd16, OP_SLL, 32'h0000_0000, "sll_zero");
        run_one(3, 32'h8000_0001, 5'd31, OP_ROR, 32'h0000_0003, "ror31_s5");
        run_one(1, 32'h1234_5678, 5'd8,  OP_ROL, 32'h3456_7812, "rol8_s1");
        run_one(2, 32'h7000_0000, 5'd3,  OP_SRA, 32'h0E00_0000, "sra_pos_s3");

        stream(0, 5, 2, 4, 1'b0, 1'b0, "bp");

        out_rdy[0] = 1'b1;
        in_vld[0]  = 1'b1;
        in_dat[0]  = 32'h1111_1111;
        in_amt[0]  = 5'd3;
        in_op[0]   = OP_SLL;
        step();
        in_dat[0]  = 32'h2222_2222;
        out_rdy[0] = 1'b0;
        step();
        chk("rst_inflight_vld", out_vld[0], 1);
        chk("rst_inflight_dat", out_dat[0], 32'h8888_8888);
        in_dat[0] = 32'h3333_3333;
        rst = 1'b1;
        step();
        chk("rst_vld",  out_vld[0], 0);
        chk("rst_dat",  out_dat[0], 0);
        chk("rst_zero", zero[0], 1);
        rst = 1'b0;
        in_vld[0]  = 1'b0;
        out_rdy[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_no_stale", out_vld[0], 0);
        end

        stream(0, 300,  0, 0, 1'b1, 1'b1, "rnd_bp");
        stream(1, 1000, 0, 0, 1'b1, 1'b0, "sweep_s1");
        stream(2, 1000, 0, 0, 1'b1, 1'b0, "sweep_s3");
        stream(3, 1000, 0, 0, 1'b1, 1'b0, "sweep_s5");
        stream(3, 200,  0, 0, 1'b1, 1'b1, "rnd_bp_s5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
